// File: rtl/dma_burst_loader_if.sv
// Bus bundle for dma_burst_loader: start/config request, memory read port, buffer result.
// i_stride is present only when DMA_STRIDE_EN is defined.
interface dma_burst_loader_if #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10
);
    logic                                   i_start;
    logic [MEM_ADDRESS_WIDTH-1:0]           i_address;
    logic [MEM_ADDRESS_WIDTH-1:0]           i_count;
`ifdef DMA_STRIDE_EN
    logic [MEM_ADDRESS_WIDTH-1:0]           i_stride;
`endif
    logic                                   o_busy;
    logic                                   o_mem_rd;
    logic [MEM_ADDRESS_WIDTH-1:0]           o_mem_addr;
    logic [WORD_SIZE-1:0]                   i_mem_data;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0]  o_buffer;
    logic                                   o_done;

    // master: controller plus memory; slave: the loader itself
    modport master (
`ifdef DMA_STRIDE_EN
        output i_stride,
`endif
        output i_start, i_address, i_count, i_mem_data,
        input  o_busy, o_mem_rd, o_mem_addr, o_buffer, o_done
    );

    modport slave (
`ifdef DMA_STRIDE_EN
        input  i_stride,
`endif
        input  i_start, i_address, i_count, i_mem_data,
        output o_busy, o_mem_rd, o_mem_addr, o_buffer, o_done
    );
endinterface

// File: rtl/dma_burst_loader.sv
// Streams min(count, BUFFER_SIZE) words from memory into a wide registered buffer.
// Optional feature macro: DMA_STRIDE_EN (strided addressing; otherwise stride is 1).
module dma_burst_loader #(
    parameter int BUFFER_SIZE       = 120,
    parameter int WORD_SIZE         = 16,
    parameter int MEM_ADDRESS_WIDTH = 10,
    parameter int MEM_LATENCY       = 1
) (
    input  logic              clk,
    input  logic              i_rst_n,
    dma_burst_loader_if.slave bus
);
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
    localparam int AW    = MEM_ADDRESS_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                            state_q, state_d;
    logic                                  rd_q, rd_d;
    logic [AW-1:0]                         addr_q, addr_d;
    logic [CNT_W-1:0]                      n_q, n_d;
    logic [CNT_W-1:0]                      issue_q, issue_d;
    logic [CNT_W-1:0]                      wr_q, wr_d;
    logic [MEM_LATENCY-1:0]                vld_pipe_q, vld_pipe_d;
    logic [BUFFER_SIZE-1:0][WORD_SIZE-1:0] buffer_q, buffer_d;
    logic [AW-1:0]                         stride;
    logic [CNT_W-1:0]                      n_clamp;
    logic [31:0]                           cnt_ext;
    logic                                  wr_en;

`ifdef DMA_STRIDE_EN
    logic [AW-1:0] stride_q, stride_d;
    assign stride = stride_q;
`else
    assign stride = AW'(1);
`endif

    assign cnt_ext = 32'(bus.i_count);
    assign n_clamp = (cnt_ext > 32'(BUFFER_SIZE)) ? CNT_W'(BUFFER_SIZE) : CNT_W'(cnt_ext);
    // the oldest pipeline slot lines up with the data returned for that strobe
    assign wr_en   = vld_pipe_q[MEM_LATENCY-1];

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        n_d        = n_q;
        issue_d    = issue_q;
        wr_d       = wr_q;
        buffer_d   = buffer_q;
        vld_pipe_d = MEM_LATENCY'({vld_pipe_q, rd_q});
`ifdef DMA_STRIDE_EN
        stride_d   = stride_q;
`endif

        if (wr_en) wr_d = wr_q + CNT_W'(1);
        for (int i = 0; i < BUFFER_SIZE; i++)
            if (wr_en && wr_q == CNT_W'(i)) buffer_d[i] = bus.i_mem_data;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    addr_d  = bus.i_address;
                    n_d     = n_clamp;
                    issue_d = '0;
                    wr_d    = '0;
`ifdef DMA_STRIDE_EN
                    stride_d = bus.i_stride;
`endif
                    if (n_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        rd_d    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_q == n_q - CNT_W'(1)) begin
                    rd_d    = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    issue_d = issue_q + CNT_W'(1);
                    addr_d  = addr_q + stride;
                end
            end
            S_DRAIN: begin
                // leave as the final word lands so DONE follows it directly
                if ((wr_en && wr_q + CNT_W'(1) == n_q) || wr_q == n_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            n_q        <= '0;
            issue_q    <= '0;
            wr_q       <= '0;
            vld_pipe_q <= '0;
            buffer_q   <= '0;
`ifdef DMA_STRIDE_EN
            stride_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            issue_q    <= issue_d;
            wr_q       <= wr_d;
            vld_pipe_q <= vld_pipe_d;
            buffer_q   <= buffer_d;
`ifdef DMA_STRIDE_EN
            stride_q   <= stride_d;
`endif
        end
    end

    assign bus.o_busy     = (state_q != S_IDLE);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_mem_rd   = rd_q;
    assign bus.o_mem_addr = addr_q;
    assign bus.o_buffer   = buffer_q;
endmodule

// File: tb/tb_dma_burst_loader.sv
// Directed bench: one loader with read latency 1 (ifa) and one with latency 3 (ifb).
module tb_dma_burst_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_burst_loader_if #(.BUFFER_SIZE(120), .WORD_SIZE(16), .MEM_ADDRESS_WIDTH(10)) ifa ();
    dma_burst_loader_if #(.BUFFER_SIZE(120), .WORD_SIZE(16), .MEM_ADDRESS_WIDTH(10)) ifb ();

    dma_burst_loader #(.BUFFER_SIZE(120), .WORD_SIZE(16), .MEM_ADDRESS_WIDTH(10), .MEM_LATENCY(1))
        u_dut_a (.clk(clk), .i_rst_n(rst_n), .bus(ifa));
    dma_burst_loader #(.BUFFER_SIZE(120), .WORD_SIZE(16), .MEM_ADDRESS_WIDTH(10), .MEM_LATENCY(3))
        u_dut_b (.clk(clk), .i_rst_n(rst_n), .bus(ifb));

    // memory: word = addr*3, garbage when no strobe
    logic [15:0] memb_pipe [3];
    always @(posedge clk) begin
        ifa.i_mem_data <= ifa.o_mem_rd ? 16'(ifa.o_mem_addr * 3) : 16'hDEAD;
        memb_pipe[0]   <= ifb.o_mem_rd ? 16'(ifb.o_mem_addr * 3) : 16'hDEAD;
        memb_pipe[1]   <= memb_pipe[0];
        memb_pipe[2]   <= memb_pipe[1];
    end
    assign ifb.i_mem_data = memb_pipe[2];

    bit sel;
    logic mrd, mdone, mbusy;
    logic [9:0] maddr;
    assign mrd   = sel ? ifb.o_mem_rd   : ifa.o_mem_rd;
    assign mdone = sel ? ifb.o_done     : ifa.o_done;
    assign mbusy = sel ? ifb.o_busy     : ifa.o_busy;
    assign maddr = sel ? ifb.o_mem_addr : ifa.o_mem_addr;

    int n_cmp = 0, n_fail = 0;
    int rd_n, rd_first, rd_last, addr_err, done_cyc, done_n;
    logic busy_at [0:200];
    logic [9:0] obs_addr [0:130];

    task automatic set_inputs(input bit s, input bit st, input int base, input int cnt, input int stride);
        if (s) begin
            ifb.i_start = st; ifb.i_address = 10'(base); ifb.i_count = 10'(cnt);
`ifdef DMA_STRIDE_EN
            ifb.i_stride = 10'(stride);
`endif
        end else begin
            ifa.i_start = st; ifa.i_address = 10'(base); ifa.i_count = 10'(cnt);
`ifdef DMA_STRIDE_EN
            ifa.i_stride = 10'(stride);
`endif
        end
    endtask

    task automatic set_start(input bit s, input bit st);
        if (s) ifb.i_start = st; else ifa.i_start = st;
    endtask

    // Start pulse in cycle 0, then observe cycles 1..maxc; returns #1 into cycle maxc+1.
    task automatic do_load(input bit s, input int base, input int cnt, input int stride,
                           input int xstart, input int maxc);
        sel = s;
        set_inputs(s, 1'b1, base, cnt, stride);
        @(posedge clk); #1;
        rd_n = 0; rd_first = -1; rd_last = -1; addr_err = 0; done_cyc = -1; done_n = 0;
        for (int c = 1; c <= maxc; c++) begin
            set_start(s, c == xstart);
            @(negedge clk);
            busy_at[c] = mbusy;
            if (mrd) begin
                if (rd_n == 0) rd_first = c;
                rd_last = c;
                if (rd_n < 131) obs_addr[rd_n] = maddr;
                if (maddr !== 10'(base + rd_n * stride)) addr_err++;
                rd_n++;
            end
            if (mdone) begin
                if (done_n == 0) done_cyc = c;
                done_n++;
            end
            @(posedge clk); #1;
        end
        set_start(s, 1'b0);
    endtask

    task automatic test_reset;
        set_inputs(0, 1'b0, 0, 0, 1);
        set_inputs(1, 1'b0, 0, 0, 1);
        #12;
        n_cmp++; if (ifa.o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_a: got %0b want 0", ifa.o_busy); end
        n_cmp++; if (ifa.o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_rd_a: got %0b want 0", ifa.o_mem_rd); end
        n_cmp++; if (ifa.o_mem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr_a: got %0d want 0", ifa.o_mem_addr); end
        n_cmp++; if (ifa.o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done_a: got %0b want 0", ifa.o_done); end
        n_cmp++; if (ifa.o_buffer !== '0) begin n_fail++; $display("FAIL rst_buf_a: got nonzero want 0"); end
        n_cmp++; if (ifb.o_busy !== 1'b0 || ifb.o_mem_rd !== 1'b0 || ifb.o_done !== 1'b0)
            begin n_fail++; $display("FAIL rst_ctl_b: got %0b%0b%0b want 000", ifb.o_busy, ifb.o_mem_rd, ifb.o_done); end
        n_cmp++; if (ifb.o_buffer !== '0) begin n_fail++; $display("FAIL rst_buf_b: got nonzero want 0"); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        do_load(0, 10, 4, 1, 0, 8);
        n_cmp++; if (rd_n !== 4) begin n_fail++; $display("FAIL basic_strobes: got %0d want 4", rd_n); end
        n_cmp++; if (rd_first !== 1 || rd_last !== 4) begin n_fail++; $display("FAIL basic_rd_window: got %0d..%0d want 1..4", rd_first, rd_last); end
        n_cmp++; if (addr_err !== 0) begin n_fail++; $display("FAIL basic_addr: got %0d bad want 0", addr_err); end
        n_cmp++; if (done_cyc !== 6 || done_n !== 1) begin n_fail++; $display("FAIL basic_done: got cyc %0d n %0d want 6 1", done_cyc, done_n); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd30) begin n_fail++; $display("FAIL basic_buf0: got %0d want 30", ifa.o_buffer[0]); end
        n_cmp++; if (ifa.o_buffer[1] !== 16'd33) begin n_fail++; $display("FAIL basic_buf1: got %0d want 33", ifa.o_buffer[1]); end
        n_cmp++; if (ifa.o_buffer[2] !== 16'd36) begin n_fail++; $display("FAIL basic_buf2: got %0d want 36", ifa.o_buffer[2]); end
        n_cmp++; if (ifa.o_buffer[3] !== 16'd39) begin n_fail++; $display("FAIL basic_buf3: got %0d want 39", ifa.o_buffer[3]); end
        n_cmp++; if (ifa.o_buffer[4] !== 16'd0) begin n_fail++; $display("FAIL basic_buf4: got %0d want 0", ifa.o_buffer[4]); end
        n_cmp++; if (busy_at[6] !== 1'b1 || busy_at[7] !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %0b%0b want 10", busy_at[6], busy_at[7]); end
    endtask

    task automatic test_start_ignored;
        do_load(0, 200, 5, 1, 2, 10);
        n_cmp++; if (rd_n !== 5) begin n_fail++; $display("FAIL ign_strobes: got %0d want 5", rd_n); end
        n_cmp++; if (done_cyc !== 7 || done_n !== 1) begin n_fail++; $display("FAIL ign_done: got cyc %0d n %0d want 7 1", done_cyc, done_n); end
        n_cmp++; if (busy_at[8] !== 1'b0 || busy_at[9] !== 1'b0) begin n_fail++; $display("FAIL ign_queued: got %0b%0b want 00", busy_at[8], busy_at[9]); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd600 || ifa.o_buffer[4] !== 16'd612)
            begin n_fail++; $display("FAIL ign_buf: got %0d,%0d want 600,612", ifa.o_buffer[0], ifa.o_buffer[4]); end
    endtask

    task automatic test_full_latency3;
        do_load(1, 0, 120, 1, 0, 126);
        n_cmp++; if (rd_n !== 120) begin n_fail++; $display("FAIL full_strobes: got %0d want 120", rd_n); end
        n_cmp++; if (rd_first !== 1 || rd_last !== 120) begin n_fail++; $display("FAIL full_rd_window: got %0d..%0d want 1..120", rd_first, rd_last); end
        n_cmp++; if (addr_err !== 0) begin n_fail++; $display("FAIL full_addr: got %0d bad want 0", addr_err); end
        n_cmp++; if (done_cyc !== 124 || done_n !== 1) begin n_fail++; $display("FAIL full_done: got cyc %0d n %0d want 124 1", done_cyc, done_n); end
        n_cmp++; if (busy_at[124] !== 1'b1 || busy_at[125] !== 1'b0) begin n_fail++; $display("FAIL full_busy: got %0b%0b want 10", busy_at[124], busy_at[125]); end
        n_cmp++; if (ifb.o_buffer[0] !== 16'd0 || ifb.o_buffer[1] !== 16'd3)
            begin n_fail++; $display("FAIL full_buf_lo: got %0d,%0d want 0,3", ifb.o_buffer[0], ifb.o_buffer[1]); end
        n_cmp++; if (ifb.o_buffer[119] !== 16'd357) begin n_fail++; $display("FAIL full_buf119: got %0d want 357", ifb.o_buffer[119]); end
    endtask

    task automatic test_clamp;
        do_load(0, 5, 200, 1, 0, 124);
        n_cmp++; if (rd_n !== 120) begin n_fail++; $display("FAIL clamp_strobes: got %0d want 120", rd_n); end
        n_cmp++; if (done_cyc !== 122) begin n_fail++; $display("FAIL clamp_done: got %0d want 122", done_cyc); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd15 || ifa.o_buffer[119] !== 16'd372)
            begin n_fail++; $display("FAIL clamp_buf: got %0d,%0d want 15,372", ifa.o_buffer[0], ifa.o_buffer[119]); end
    endtask

    task automatic test_zero;
        do_load(0, 300, 0, 1, 0, 4);
        n_cmp++; if (rd_n !== 0) begin n_fail++; $display("FAIL zero_strobes: got %0d want 0", rd_n); end
        n_cmp++; if (done_cyc !== 1 || done_n !== 1) begin n_fail++; $display("FAIL zero_done: got cyc %0d n %0d want 1 1", done_cyc, done_n); end
        n_cmp++; if (busy_at[2] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %0b want 0", busy_at[2]); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd15 || ifa.o_buffer[119] !== 16'd372)
            begin n_fail++; $display("FAIL zero_buf_kept: got %0d,%0d want 15,372", ifa.o_buffer[0], ifa.o_buffer[119]); end
    endtask

    task automatic test_back_to_back;
        do_load(0, 40, 3, 1, 0, 5);
        n_cmp++; if (done_cyc !== 5) begin n_fail++; $display("FAIL b2b_done1: got %0d want 5", done_cyc); end
        do_load(0, 60, 3, 1, 0, 5);
        n_cmp++; if (rd_n !== 3 || rd_first !== 1) begin n_fail++; $display("FAIL b2b_strobes2: got %0d from %0d want 3 from 1", rd_n, rd_first); end
        n_cmp++; if (done_cyc !== 5) begin n_fail++; $display("FAIL b2b_done2: got %0d want 5", done_cyc); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd180 || ifa.o_buffer[2] !== 16'd186)
            begin n_fail++; $display("FAIL b2b_buf: got %0d,%0d want 180,186", ifa.o_buffer[0], ifa.o_buffer[2]); end
        n_cmp++; if (ifa.o_buffer[3] !== 16'd24) begin n_fail++; $display("FAIL b2b_buf3_kept: got %0d want 24", ifa.o_buffer[3]); end
    endtask

`ifdef DMA_STRIDE_EN
    task automatic test_stride;
        do_load(0, 1020, 3, 3, 0, 6);
        n_cmp++; if (rd_n !== 3) begin n_fail++; $display("FAIL stride_strobes: got %0d want 3", rd_n); end
        n_cmp++; if (obs_addr[0] !== 10'd1020 || obs_addr[1] !== 10'd1023 || obs_addr[2] !== 10'd2)
            begin n_fail++; $display("FAIL stride_wrap: got %0d,%0d,%0d want 1020,1023,2", obs_addr[0], obs_addr[1], obs_addr[2]); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd3060 || ifa.o_buffer[2] !== 16'd6)
            begin n_fail++; $display("FAIL stride_buf: got %0d,%0d want 3060,6", ifa.o_buffer[0], ifa.o_buffer[2]); end
        do_load(0, 7, 3, 0, 0, 6);
        n_cmp++; if (rd_n !== 3 || addr_err !== 0) begin n_fail++; $display("FAIL stride0: got %0d strobes %0d bad want 3 0", rd_n, addr_err); end
    endtask
`endif

    task automatic test_abort;
        sel = 0;
        set_inputs(0, 1'b1, 100, 8, 1);
        @(posedge clk); #1; set_start(0, 1'b0);
        @(posedge clk); #1; set_start(0, 1'b1);
        @(posedge clk); #1; set_start(0, 1'b0);
        n_cmp++; if (ifa.o_mem_rd !== 1'b1 || ifa.o_buffer[0] !== 16'd300)
            begin n_fail++; $display("FAIL abort_pre: got rd %0b buf0 %0d want 1 300", ifa.o_mem_rd, ifa.o_buffer[0]); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++; if (ifa.o_busy !== 1'b0 || ifa.o_mem_rd !== 1'b0 || ifa.o_done !== 1'b0)
            begin n_fail++; $display("FAIL abort_ctl: got %0b%0b%0b want 000", ifa.o_busy, ifa.o_mem_rd, ifa.o_done); end
        n_cmp++; if (ifa.o_mem_addr !== 10'd0) begin n_fail++; $display("FAIL abort_addr: got %0d want 0", ifa.o_mem_addr); end
        n_cmp++; if (ifa.o_buffer !== '0) begin n_fail++; $display("FAIL abort_buf: got nonzero want 0"); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_load(0, 50, 2, 1, 0, 6);
        n_cmp++; if (rd_n !== 2 || done_cyc !== 4) begin n_fail++; $display("FAIL abort_next: got %0d strobes done %0d want 2 4", rd_n, done_cyc); end
        n_cmp++; if (ifa.o_buffer[0] !== 16'd150 || ifa.o_buffer[1] !== 16'd153 || ifa.o_buffer[2] !== 16'd0)
            begin n_fail++; $display("FAIL abort_next_buf: got %0d,%0d,%0d want 150,153,0", ifa.o_buffer[0], ifa.o_buffer[1], ifa.o_buffer[2]); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_start_ignored;
        test_full_latency3;
        test_clamp;
        test_zero;
        test_back_to_back;
`ifdef DMA_STRIDE_EN
        test_stride;
`endif
        test_abort;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_burst_loader.md
# dma_burst_loader

Parametrised successor to the fully-connected layer's single-channel buffer loader. On a start pulse it streams `count` words from weight/activation memory into a wide parallel buffer. It adds:
- a single-edge (posedge-only) pipeline;
- configurable memory read latency;
- strided addressing;
- explicit busy/done handshakes;
- count clamping.

It sits between on-chip memory and the FC datapath, which consumes `o_buffer` after `o_done`.

## Interface
- `BUFFER_SIZE`, 120, number of buffer words (1..1023).
- `WORD_SIZE`, 16, bits per word.
- `MEM_ADDRESS_WIDTH`, 10, memory address width.
- `MEM_LATENCY`, 1, cycles from address issue to data valid (1..4).
- `clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start request, sampled only in IDLE.
- `i_address`  in  MEM_ADDRESS_WIDTH  base address.
- `i_count`  in  MEM_ADDRESS_WIDTH  words to load.
- `i_stride`  in  MEM_ADDRESS_WIDTH  address increment; present only with `DMA_STRIDE_EN`.
- `o_busy`  out  1  high in every state except IDLE.
- `o_mem_rd`  out  1  read strobe, one word per cycle.
- `o_mem_addr`  out  MEM_ADDRESS_WIDTH  read address, registered.
- `i_mem_data`  in  WORD_SIZE  read data, valid MEM_LATENCY cycles after its strobe.
- `o_buffer`  out  [BUFFER_SIZE-1:0][WORD_SIZE-1:0]  loaded words, registered.
- `o_done`  out  1  one-cycle completion pulse.

## Operation
- Reset values: FSM IDLE; `o_busy`=0, `o_mem_rd`=0, `o_mem_addr`=0, `o_done`=0; every `o_buffer` word 0. Issue index, write index and latency pipeline are cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE, `i_start`=1:
  - latch base address and stride;
  - latch N = min(`i_count`, BUFFER_SIZE);
  - go to DONE if N=0, else ISSUE.
- ISSUE: assert `o_mem_rd` each cycle with `o_mem_addr` = base + k·stride, for k=0..N-1. Go to DRAIN after the k=N-1 issue.
- Capture: a MEM_LATENCY-deep valid shift register tracks each strobe. When a tracked strobe reaches the end of the pipeline, `o_buffer[w]` ← `i_mem_data` and w increments. Capture runs in both ISSUE and DRAIN.
- DRAIN: `o_mem_rd`=0. Go to DONE when w = N.
- DONE: `o_done`=1 for exactly one cycle, then IDLE.
- Address arithmetic is modulo 2^MEM_ADDRESS_WIDTH; wrap is silent.
- Buffer words at indices ≥ N keep their previous contents.
- `i_start` in ISSUE, DRAIN or DONE is ignored and is not queued. Inputs other than `i_start` are don't-care outside IDLE.
- Reset asserted mid-transfer: immediate return to reset values. In-flight reads are discarded; the partial buffer is cleared.

## Timing
- Start sampled at edge 0.
- ISSUE spans cycles 1..N; `o_mem_rd` is high during exactly N consecutive cycles.
- Data for the strobe in cycle c is valid in cycle c+L, where L = MEM_LATENCY. It is captured at the end of cycle c+L.
- The last buffer word is written at the end of cycle N+L.
- DONE (`o_done`=1) occurs in cycle N+L+1; IDLE resumes in cycle N+L+2.
- A new `i_start` is accepted at the end of cycle N+L+2 at earliest.
- N=0: DONE in cycle 1, with no strobes issued.
- Total latency for N words: N+L+1 cycles, start to `o_done`.

## Configuration
- `DMA_STRIDE_EN` defined:
  - `i_stride` port exists and is latched at start;
  - stride 0 is legal and re-reads the base address N times.
- `DMA_STRIDE_EN` undefined:
  - no `i_stride` port;
  - stride is hard-wired to 1 (contiguous burst).

## Test plan
- Reset, L=1, address=10, count=4, memory word=addr·3: strobes at 10..13 in cycles 1..4; `o_buffer[0..3]`=30,33,36,39; `o_done` in cycle 6.
- L=3, count=BUFFER_SIZE=120, base 0: 120 consecutive strobes; `o_done` in cycle 124; `o_busy` low in cycle 125.
- count=200: clamped to 120 strobes. count=0: no strobe, `o_done` in cycle 1, buffer unchanged.
- `DMA_STRIDE_EN`, base=1020, stride=3, count=3, W=10: addresses 1020, 1023, 2 (wrap).
- `i_start` pulsed during ISSUE, then reset asserted at cycle 3 of an 8-word load: second start ignored; all outputs 0 immediately, buffer cleared, FSM in IDLE; next start behaves normally.
